// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : TileLink-UL opcode constants, D error flags and helper
//               functions shared by the width widget and its D merger.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] C_TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] C_TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] C_TL_GET             = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] C_TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] C_TL_ACCESS_ACK_DATA = 3'd1;

  // Error flags accumulated across absorbed D sub-beats
  typedef struct packed {
    logic denied;
    logic corrupt;
  } tl_d_err_t;

  // True for A-channel requests that carry write data
  function automatic logic has_data(input logic [2:0] opcode);
    return (opcode == C_TL_PUT_FULL) || (opcode == C_TL_PUT_PARTIAL);
  endfunction

  // Ceiling log2 usable in constant expressions (clog2(1) = 0)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : tl_pkg
`default_nettype wire

// File: rtl/tl_d_merge.sv
`default_nettype none
// ============================================================================
// Module      : tl_d_merge
// Description : D-channel accumulator. Absorbs the first RATIO-1 narrow
//               AccessAckData sub-beats of a wide response and releases one
//               wide beat with the final sub-beat. Other responses pass
//               through with data replicated across the wide bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_d_merge
  import tl_pkg::*;
#(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 4,
  parameter int SIZE_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // narrow side (manager D)
  input  logic                   i_out_valid,
  output logic                   o_out_ready,
  input  logic [2:0]             i_opcode,
  input  logic [SIZE_W-1:0]      i_size,
  input  logic                   i_denied,
  input  logic                   i_corrupt,
  input  logic [8*OUT_BYTES-1:0] i_data,
  // wide side (client D)
  output logic                   o_in_valid,
  input  logic                   i_in_ready,
  output logic [8*IN_BYTES-1:0]  o_data,
  output logic                   o_denied,
  output logic                   o_corrupt
);

  localparam int RATIO = IN_BYTES / OUT_BYTES;
  localparam logic [SIZE_W-1:0] C_LG_SIZE = SIZE_W'(clog2(OUT_BYTES));

  generate
    if (RATIO == 1) begin : g_wire
      assign o_out_ready = i_in_ready;
      assign o_in_valid  = i_out_valid;
      assign o_data      = i_data;
      assign o_denied    = i_denied;
      assign o_corrupt   = i_corrupt;
    end else begin : g_merge
      localparam int CW    = clog2(RATIO);
      localparam int OW    = 8 * OUT_BYTES;
      localparam int BUF_W = (RATIO - 1) * OW;

      logic [CW-1:0]    r_d_cnt;
      logic [BUF_W-1:0] r_d_buf;
      tl_d_err_t        r_d_err;
      logic             w_merge;
      logic             w_last;
      logic             w_fire;

      // Only wide data responses are reassembled; everything else is passed on
      assign w_merge = (i_opcode == C_TL_ACCESS_ACK_DATA) && (i_size > C_LG_SIZE);
      assign w_last  = (r_d_cnt == CW'(RATIO - 1));
      assign w_fire  = i_out_valid && o_out_ready;

      // Handshake and data steering: absorb early sub-beats, forward the last
      always_comb begin
        o_out_ready = i_in_ready;
        o_in_valid  = i_out_valid;
        o_data      = {RATIO{i_data}};
        o_denied    = i_denied;
        o_corrupt   = i_corrupt;
        if (w_merge) begin
          if (!w_last) begin
            o_out_ready = 1'b1;
            o_in_valid  = 1'b0;
          end else begin
            o_data    = {i_data, r_d_buf};
            o_denied  = i_denied | r_d_err.denied;
            o_corrupt = i_corrupt | r_d_err.corrupt;
          end
        end
      end

      // Sub-beat counter, data buffer and sticky error flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_d_cnt <= '0;
          r_d_buf <= '0;
          r_d_err <= '0;
        end else if (w_merge && w_fire) begin
          if (w_last) begin
            r_d_cnt <= '0;
            r_d_err <= '0;
          end else begin
            r_d_cnt         <= r_d_cnt + 1'b1;
            r_d_err.denied  <= r_d_err.denied | i_denied;
            r_d_err.corrupt <= r_d_err.corrupt | i_corrupt;
            for (int k = 0; k < RATIO - 1; k++) begin
              if (r_d_cnt == CW'(k)) r_d_buf[k*OW +: OW] <= i_data;
            end
          end
        end
      end
    end
  endgenerate

endmodule : tl_d_merge
`default_nettype wire

// File: rtl/tl_width_widget_narrow.sv
`default_nettype none
// ============================================================================
// Module      : tl_width_widget_narrow
// Description : TileLink-UL width converter from a wide client to a narrow
//               manager. A channel: wide puts are split into RATIO sub-beats
//               with zero latency; narrow puts and gets are lane-selected.
//               D channel: wide AccessAckData is merged by tl_d_merge.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_width_widget_narrow
  import tl_pkg::*;
#(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 4,
  parameter int ADDR_W    = 31,
  parameter int SRC_W     = 5,
  parameter int SIZE_W    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  // client A
  output logic                   auto_in_a_ready,
  input  logic                   auto_in_a_valid,
  input  logic [2:0]             auto_in_a_bits_opcode,
  input  logic [2:0]             auto_in_a_bits_param,
  input  logic [SIZE_W-1:0]      auto_in_a_bits_size,
  input  logic [SRC_W-1:0]       auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]      auto_in_a_bits_address,
  input  logic [IN_BYTES-1:0]    auto_in_a_bits_mask,
  input  logic [8*IN_BYTES-1:0]  auto_in_a_bits_data,
  input  logic                   auto_in_a_bits_corrupt,
  // client D
  input  logic                   auto_in_d_ready,
  output logic                   auto_in_d_valid,
  output logic [2:0]             auto_in_d_bits_opcode,
  output logic [1:0]             auto_in_d_bits_param,
  output logic [SIZE_W-1:0]      auto_in_d_bits_size,
  output logic [SRC_W-1:0]       auto_in_d_bits_source,
  output logic                   auto_in_d_bits_sink,
  output logic                   auto_in_d_bits_denied,
  output logic [8*IN_BYTES-1:0]  auto_in_d_bits_data,
  output logic                   auto_in_d_bits_corrupt,
  // manager A
  input  logic                   auto_out_a_ready,
  output logic                   auto_out_a_valid,
  output logic [2:0]             auto_out_a_bits_opcode,
  output logic [2:0]             auto_out_a_bits_param,
  output logic [SIZE_W-1:0]      auto_out_a_bits_size,
  output logic [SRC_W-1:0]       auto_out_a_bits_source,
  output logic [ADDR_W-1:0]      auto_out_a_bits_address,
  output logic [OUT_BYTES-1:0]   auto_out_a_bits_mask,
  output logic [8*OUT_BYTES-1:0] auto_out_a_bits_data,
  output logic                   auto_out_a_bits_corrupt,
  // manager D
  output logic                   auto_out_d_ready,
  input  logic                   auto_out_d_valid,
  input  logic [2:0]             auto_out_d_bits_opcode,
  input  logic [1:0]             auto_out_d_bits_param,
  input  logic [SIZE_W-1:0]      auto_out_d_bits_size,
  input  logic [SRC_W-1:0]       auto_out_d_bits_source,
  input  logic                   auto_out_d_bits_sink,
  input  logic                   auto_out_d_bits_denied,
  input  logic [8*OUT_BYTES-1:0] auto_out_d_bits_data,
  input  logic                   auto_out_d_bits_corrupt
);

  localparam int RATIO = IN_BYTES / OUT_BYTES;
  localparam logic [SIZE_W-1:0] C_LG_SIZE = SIZE_W'(clog2(OUT_BYTES));

  // Header fields travel unchanged on every A sub-beat and every D beat
  assign auto_out_a_valid        = auto_in_a_valid;
  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_source  = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

  assign auto_in_d_bits_opcode   = auto_out_d_bits_opcode;
  assign auto_in_d_bits_param    = auto_out_d_bits_param;
  assign auto_in_d_bits_size     = auto_out_d_bits_size;
  assign auto_in_d_bits_source   = auto_out_d_bits_source;
  assign auto_in_d_bits_sink     = auto_out_d_bits_sink;

  generate
    if (RATIO == 1) begin : g_a_wire
      assign auto_out_a_bits_mask = auto_in_a_bits_mask;
      assign auto_out_a_bits_data = auto_in_a_bits_data;
      assign auto_in_a_ready      = auto_out_a_ready;
    end else begin : g_a_split
      localparam int CW    = clog2(RATIO);
      localparam int OW    = 8 * OUT_BYTES;
      localparam int IN_LG = clog2(IN_BYTES);
      localparam int LG    = clog2(OUT_BYTES);

      logic [CW-1:0] r_a_cnt;
      logic [CW-1:0] w_sel;
      logic          w_narrow;
      logic          w_wide;
      logic          w_last;

      assign w_narrow = (auto_in_a_bits_size <= C_LG_SIZE);
      assign w_wide   = has_data(auto_in_a_bits_opcode) && !w_narrow;
      assign w_last   = (r_a_cnt == CW'(RATIO - 1));
      // Wide puts walk the lanes in order; everything else uses the address lane
      assign w_sel    = w_wide ? r_a_cnt : auto_in_a_bits_address[IN_LG-1:LG];

      // Lane multiplexer for data and mask; wide gets read every narrow byte
      always_comb begin
        auto_out_a_bits_data = '0;
        auto_out_a_bits_mask = '0;
        for (int k = 0; k < RATIO; k++) begin
          if (w_sel == CW'(k)) begin
            auto_out_a_bits_data = auto_in_a_bits_data[k*OW +: OW];
            auto_out_a_bits_mask = auto_in_a_bits_mask[k*OUT_BYTES +: OUT_BYTES];
          end
        end
        if (!has_data(auto_in_a_bits_opcode) && !w_narrow) auto_out_a_bits_mask = '1;
      end

      // The client beat retires only with the final sub-beat of a wide put
      assign auto_in_a_ready = auto_out_a_ready && (!w_wide || w_last);

      // Sub-beat counter for wide puts
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_a_cnt <= '0;
        end else if (w_wide && auto_in_a_valid && auto_out_a_ready) begin
          r_a_cnt <= w_last ? '0 : r_a_cnt + 1'b1;
        end
      end
    end
  endgenerate

  tl_d_merge #(
    .IN_BYTES  (IN_BYTES),
    .OUT_BYTES (OUT_BYTES),
    .SIZE_W    (SIZE_W)
  ) u_d_merge (
    .clk         (clock),
    .rst_n       (reset),
    .i_out_valid (auto_out_d_valid),
    .o_out_ready (auto_out_d_ready),
    .i_opcode    (auto_out_d_bits_opcode),
    .i_size      (auto_out_d_bits_size),
    .i_denied    (auto_out_d_bits_denied),
    .i_corrupt   (auto_out_d_bits_corrupt),
    .i_data      (auto_out_d_bits_data),
    .o_in_valid  (auto_in_d_valid),
    .i_in_ready  (auto_in_d_ready),
    .o_data      (auto_in_d_bits_data),
    .o_denied    (auto_in_d_bits_denied),
    .o_corrupt   (auto_in_d_bits_corrupt)
  );

endmodule : tl_width_widget_narrow
`default_nettype wire

// File: tb/tb_tl_width_widget_narrow.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_width_widget_narrow
// Description : Self-checking bench for the 8->4 byte TileLink width widget.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_width_widget_narrow;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        auto_in_a_ready, auto_in_a_valid;
  logic [2:0]  auto_in_a_bits_opcode, auto_in_a_bits_param;
  logic [2:0]  auto_in_a_bits_size;
  logic [4:0]  auto_in_a_bits_source;
  logic [30:0] auto_in_a_bits_address;
  logic [7:0]  auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;
  logic        auto_in_a_bits_corrupt;
  logic        auto_in_d_ready, auto_in_d_valid;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_param;
  logic [2:0]  auto_in_d_bits_size;
  logic [4:0]  auto_in_d_bits_source;
  logic        auto_in_d_bits_sink, auto_in_d_bits_denied;
  logic [63:0] auto_in_d_bits_data;
  logic        auto_in_d_bits_corrupt;
  logic        auto_out_a_ready, auto_out_a_valid;
  logic [2:0]  auto_out_a_bits_opcode, auto_out_a_bits_param;
  logic [2:0]  auto_out_a_bits_size;
  logic [4:0]  auto_out_a_bits_source;
  logic [30:0] auto_out_a_bits_address;
  logic [3:0]  auto_out_a_bits_mask;
  logic [31:0] auto_out_a_bits_data;
  logic        auto_out_a_bits_corrupt;
  logic        auto_out_d_ready, auto_out_d_valid;
  logic [2:0]  auto_out_d_bits_opcode;
  logic [1:0]  auto_out_d_bits_param;
  logic [2:0]  auto_out_d_bits_size;
  logic [4:0]  auto_out_d_bits_source;
  logic        auto_out_d_bits_sink, auto_out_d_bits_denied;
  logic [31:0] auto_out_d_bits_data;
  logic        auto_out_d_bits_corrupt;

  tl_width_widget_narrow dut (
    .clock(clk), .reset(rst_n),
    .auto_in_a_ready(auto_in_a_ready), .auto_in_a_valid(auto_in_a_valid),
    .auto_in_a_bits_opcode(auto_in_a_bits_opcode), .auto_in_a_bits_param(auto_in_a_bits_param),
    .auto_in_a_bits_size(auto_in_a_bits_size), .auto_in_a_bits_source(auto_in_a_bits_source),
    .auto_in_a_bits_address(auto_in_a_bits_address), .auto_in_a_bits_mask(auto_in_a_bits_mask),
    .auto_in_a_bits_data(auto_in_a_bits_data), .auto_in_a_bits_corrupt(auto_in_a_bits_corrupt),
    .auto_in_d_ready(auto_in_d_ready), .auto_in_d_valid(auto_in_d_valid),
    .auto_in_d_bits_opcode(auto_in_d_bits_opcode), .auto_in_d_bits_param(auto_in_d_bits_param),
    .auto_in_d_bits_size(auto_in_d_bits_size), .auto_in_d_bits_source(auto_in_d_bits_source),
    .auto_in_d_bits_sink(auto_in_d_bits_sink), .auto_in_d_bits_denied(auto_in_d_bits_denied),
    .auto_in_d_bits_data(auto_in_d_bits_data), .auto_in_d_bits_corrupt(auto_in_d_bits_corrupt),
    .auto_out_a_ready(auto_out_a_ready), .auto_out_a_valid(auto_out_a_valid),
    .auto_out_a_bits_opcode(auto_out_a_bits_opcode), .auto_out_a_bits_param(auto_out_a_bits_param),
    .auto_out_a_bits_size(auto_out_a_bits_size), .auto_out_a_bits_source(auto_out_a_bits_source),
    .auto_out_a_bits_address(auto_out_a_bits_address), .auto_out_a_bits_mask(auto_out_a_bits_mask),
    .auto_out_a_bits_data(auto_out_a_bits_data), .auto_out_a_bits_corrupt(auto_out_a_bits_corrupt),
    .auto_out_d_ready(auto_out_d_ready), .auto_out_d_valid(auto_out_d_valid),
    .auto_out_d_bits_opcode(auto_out_d_bits_opcode), .auto_out_d_bits_param(auto_out_d_bits_param),
    .auto_out_d_bits_size(auto_out_d_bits_size), .auto_out_d_bits_source(auto_out_d_bits_source),
    .auto_out_d_bits_sink(auto_out_d_bits_sink), .auto_out_d_bits_denied(auto_out_d_bits_denied),
    .auto_out_d_bits_data(auto_out_d_bits_data), .auto_out_d_bits_corrupt(auto_out_d_bits_corrupt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [30:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
    logic [4:0]  src;
    int          n;
  } a_op_t;
  typedef struct { logic [31:0] data; logic [3:0] mask; } a_beat_t;
  typedef struct {
    logic [2:0] op; logic [2:0] size; logic [31:0] data;
    logic denied; logic corrupt; logic [4:0] src;
  } d_beat_t;
  typedef struct {
    logic [63:0] data; logic [2:0] op; logic [2:0] size;
    logic denied; logic corrupt; logic [4:0] src;
  } d_exp_t;

  a_op_t   a_q[$];
  a_beat_t ea_q[$];
  d_beat_t d_q[$];
  d_exp_t  ed_q[$];

  // Expected manager beats: a put wider than 4 bytes becomes two 4-byte beats
  // in address order; anything else is one beat taken from the addressed lane.
  function automatic void add_a(input logic [2:0] op, input logic [2:0] size, input logic [30:0] addr,
                                input logic [7:0] mask, input logic [63:0] data, input logic corrupt,
                                input logic [4:0] src);
    a_op_t o; a_beat_t b; int lane;
    o.op = op; o.size = size; o.addr = addr; o.mask = mask; o.data = data;
    o.corrupt = corrupt; o.src = src;
    o.n = ((op == 3'd0 || op == 3'd1) && size > 3'd2) ? 2 : 1;
    a_q.push_back(o);
    if (o.n == 2) begin
      for (int k = 0; k < 2; k++) begin
        b.data = 32'(data >> (32 * k));
        b.mask = 4'(mask >> (4 * k));
        ea_q.push_back(b);
      end
    end else begin
      lane   = int'((addr / 4) % 2);
      b.data = 32'(data >> (32 * lane));
      b.mask = (op == 3'd4 && size > 3'd2) ? 4'hF : 4'(mask >> (4 * lane));
      ea_q.push_back(b);
    end
  endfunction

  // A response of 2^size bytes; wide data responses pair narrow beats
  // (first beat = low half), other responses show the beat on both halves.
  function automatic void add_d(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                                input bit rnd_err);
    d_beat_t b0, b1; d_exp_t e; int nb;
    if (op == 3'd1 && size > 3'd2) begin
      nb = (1 << size) / 4;
      for (int j = 0; j < nb / 2; j++) begin
        b0.op = op; b0.size = size; b0.src = src; b0.data = $urandom;
        b0.corrupt = rnd_err ? ($urandom % 5 == 0) : 1'b0;
        b0.denied  = rnd_err ? ($urandom % 7 == 0) : 1'b0;
        b1 = b0; b1.data = $urandom;
        b1.corrupt = rnd_err ? ($urandom % 5 == 0) : 1'b0;
        b1.denied  = rnd_err ? ($urandom % 7 == 0) : 1'b0;
        d_q.push_back(b0); d_q.push_back(b1);
        e.op = op; e.size = size; e.src = src;
        e.data = {b1.data, b0.data};
        e.corrupt = b0.corrupt | b1.corrupt;
        e.denied  = b0.denied | b1.denied;
        ed_q.push_back(e);
      end
    end else begin
      b0.op = op; b0.size = size; b0.src = src; b0.data = $urandom;
      b0.corrupt = rnd_err ? ($urandom % 5 == 0) : 1'b0;
      b0.denied  = rnd_err ? ($urandom % 7 == 0) : 1'b0;
      d_q.push_back(b0);
      e.op = op; e.size = size; e.src = src; e.data = {b0.data, b0.data};
      e.corrupt = b0.corrupt; e.denied = b0.denied;
      ed_q.push_back(e);
    end
  endfunction

  // ---------------- queue-driven traffic engine ----------------
  task automatic run(input int budget, input bit bp);
    bit a_act = 0, d_act = 0;
    int a_beats = 0, cyc = 0;
    a_op_t ac; d_beat_t dc; a_beat_t eb; d_exp_t ee;
    while ((a_q.size() > 0 || a_act || d_q.size() > 0 || d_act || ed_q.size() > 0) && cyc < budget) begin
      if (!a_act) begin
        if (a_q.size() > 0 && (!bp || $urandom % 3 != 0)) begin
          ac = a_q.pop_front(); a_act = 1; a_beats = 0;
          auto_in_a_bits_opcode = ac.op; auto_in_a_bits_size = ac.size;
          auto_in_a_bits_address = ac.addr; auto_in_a_bits_mask = ac.mask;
          auto_in_a_bits_data = ac.data; auto_in_a_bits_corrupt = ac.corrupt;
          auto_in_a_bits_source = ac.src; auto_in_a_valid = 1'b1;
        end else auto_in_a_valid = 1'b0;
      end
      if (!d_act) begin
        if (d_q.size() > 0 && (!bp || $urandom % 3 != 0)) begin
          dc = d_q.pop_front(); d_act = 1;
          auto_out_d_bits_opcode = dc.op; auto_out_d_bits_size = dc.size;
          auto_out_d_bits_data = dc.data; auto_out_d_bits_corrupt = dc.corrupt;
          auto_out_d_bits_denied = dc.denied; auto_out_d_bits_source = dc.src;
          auto_out_d_valid = 1'b1;
        end else auto_out_d_valid = 1'b0;
      end
      auto_out_a_ready = bp ? ($urandom % 4 != 0) : 1'b1;
      auto_in_d_ready  = bp ? ($urandom % 4 != 0) : 1'b1;
      @(negedge clk);
      if (auto_out_a_valid && auto_out_a_ready) begin
        if (ea_q.size() == 0) check_eq("a_extra_beat", 1, 0);
        else begin
          eb = ea_q.pop_front();
          check_eq("a_data", auto_out_a_bits_data, eb.data);
          check_eq("a_mask", auto_out_a_bits_mask, eb.mask);
          check_eq("a_addr", auto_out_a_bits_address, ac.addr);
          check_eq("a_hdr", {auto_out_a_bits_opcode, auto_out_a_bits_size, auto_out_a_bits_source,
                             auto_out_a_bits_corrupt}, {ac.op, ac.size, ac.src, ac.corrupt});
        end
        a_beats++;
      end
      if (auto_in_a_valid && auto_in_a_ready) begin
        check_eq("a_beats_per_op", a_beats, ac.n);
        a_act = 0;
      end
      if (auto_out_d_valid && auto_out_d_ready) d_act = 0;
      if (auto_in_d_valid && auto_in_d_ready) begin
        if (ed_q.size() == 0) check_eq("d_extra_beat", 1, 0);
        else begin
          ee = ed_q.pop_front();
          check_eq("d_data", auto_in_d_bits_data, ee.data);
          check_eq("d_hdr", {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source},
                   {ee.op, ee.size, ee.src});
          check_eq("d_err", {auto_in_d_bits_denied, auto_in_d_bits_corrupt}, {ee.denied, ee.corrupt});
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= budget) check_eq("run_timeout", 1, 0);
    auto_in_a_valid = 1'b0; auto_out_d_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] op, sz;
    int r;
    rst_n = 1'b0;
    auto_in_a_valid = 0; auto_in_a_bits_opcode = 0; auto_in_a_bits_param = 0; auto_in_a_bits_size = 0;
    auto_in_a_bits_source = 0; auto_in_a_bits_address = 0; auto_in_a_bits_mask = 0;
    auto_in_a_bits_data = 0; auto_in_a_bits_corrupt = 0; auto_in_d_ready = 0;
    auto_out_a_ready = 0; auto_out_d_valid = 0; auto_out_d_bits_opcode = 0; auto_out_d_bits_param = 0;
    auto_out_d_bits_size = 0; auto_out_d_bits_source = 0; auto_out_d_bits_sink = 0;
    auto_out_d_bits_denied = 0; auto_out_d_bits_data = 0; auto_out_d_bits_corrupt = 0;

    // Reset state: a wide put held at the input shows sub-beat 0 and no ready
    auto_in_a_valid = 1; auto_in_a_bits_size = 3'd3; auto_in_a_bits_mask = 8'hFF;
    auto_in_a_bits_data = 64'hAAAA5555_01234567; auto_out_a_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_a_valid", auto_out_a_valid, 1);
    check_eq("rst_a_data", auto_out_a_bits_data, 32'h01234567);
    check_eq("rst_in_a_ready", auto_in_a_ready, 0);
    check_eq("rst_in_d_valid", auto_in_d_valid, 0);
    auto_in_a_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: wide PutFull splits into two beats, low half first
    add_a(3'd0, 3'd3, 31'h100, 8'hFF, 64'h11112222_33334444, 1'b0, 5'd3);
    run(50, 0);
    // 2: narrow PutPartial on the upper lane
    add_a(3'd1, 3'd2, 31'h104, 8'hF0, 64'hDEADBEEF_00000000, 1'b0, 5'd4);
    run(50, 0);
    // 3: 64-byte Get: one request beat, 16 narrow responses merged into 8
    add_a(3'd4, 3'd6, 31'h0, 8'hFF, 64'h0, 1'b0, 5'd5);
    add_d(3'd1, 3'd6, 5'd5, 0);
    run(200, 0);

    // 4: corrupt on first sub-beat survives; stalled client holds the manager
    auto_out_d_valid = 1; auto_out_d_bits_opcode = 3'd1; auto_out_d_bits_size = 3'd3;
    auto_out_d_bits_data = 32'hAAAA0001; auto_out_d_bits_corrupt = 1; auto_out_d_bits_denied = 0;
    auto_in_d_ready = 0;
    @(negedge clk);
    check_eq("t4_absorb_ready", auto_out_d_ready, 1);
    check_eq("t4_absorb_valid", auto_in_d_valid, 0);
    @(posedge clk); #1;
    auto_out_d_bits_data = 32'hBBBB0002; auto_out_d_bits_corrupt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("t4_stall_ready", auto_out_d_ready, 0);
      check_eq("t4_stall_valid", auto_in_d_valid, 1);
      @(posedge clk); #1;
    end
    auto_in_d_ready = 1;
    @(negedge clk);
    check_eq("t4_release_ready", auto_out_d_ready, 1);
    check_eq("t4_data", auto_in_d_bits_data, 64'hBBBB0002_AAAA0001);
    check_eq("t4_corrupt", auto_in_d_bits_corrupt, 1);
    @(posedge clk); #1;
    auto_out_d_valid = 0;

    // 5a: reset after the first sub-beat of a wide put restarts the split
    auto_in_a_valid = 1; auto_in_a_bits_opcode = 3'd0; auto_in_a_bits_size = 3'd3;
    auto_in_a_bits_data = 64'hCAFEF00D_12345678; auto_in_a_bits_mask = 8'hFF; auto_out_a_ready = 1;
    @(negedge clk);
    check_eq("t5_a_beat0", auto_out_a_bits_data, 32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t5_a_beat1", auto_out_a_bits_data, 32'hCAFEF00D);
    rst_n = 1'b0; #1;
    check_eq("t5_a_in_reset", auto_out_a_bits_data, 32'h12345678);
    check_eq("t5_a_rdy_in_reset", auto_in_a_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_a_restart0", auto_out_a_bits_data, 32'h12345678);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("t5_a_restart1", auto_out_a_bits_data, 32'hCAFEF00D);
    check_eq("t5_a_restart_rdy", auto_in_a_ready, 1);
    @(posedge clk); #1;
    auto_in_a_valid = 0;
    // 5b: reset mid-merge discards the buffered sub-beat
    auto_out_d_valid = 1; auto_out_d_bits_opcode = 3'd1; auto_out_d_bits_size = 3'd3;
    auto_out_d_bits_data = 32'h0BAD0BAD; auto_out_d_bits_corrupt = 1; auto_in_d_ready = 1;
    @(negedge clk);
    check_eq("t5_d_absorb", auto_in_d_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    auto_out_d_bits_data = 32'h00000001; auto_out_d_bits_corrupt = 0; #1;
    check_eq("t5_d_in_reset", auto_in_d_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_d_restart0", auto_in_d_valid, 0);
    @(posedge clk); #1;
    auto_out_d_bits_data = 32'h00000002;
    @(negedge clk);
    check_eq("t5_d_restart_valid", auto_in_d_valid, 1);
    check_eq("t5_d_restart_data", auto_in_d_bits_data, 64'h00000002_00000001);
    check_eq("t5_d_restart_corrupt", auto_in_d_bits_corrupt, 0);
    @(posedge clk); #1;
    auto_out_d_valid = 0;

    // 6: mixed random traffic on both channels with back-pressure
    for (int i = 0; i < 500; i++) begin
      r  = $urandom % 3;
      op = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd4;
      sz = 3'($urandom % 4);
      add_a(op, sz, 31'($urandom), 8'($urandom), {$urandom, $urandom}, 1'($urandom), 5'($urandom));
      r = $urandom % 3;
      if (r == 0)      add_d(3'd1, 3'd3 + 3'($urandom % 2), 5'($urandom), 1);
      else if (r == 1) add_d(3'd1, 3'($urandom % 3), 5'($urandom), 1);
      else             add_d(3'd0, 3'($urandom % 5), 5'($urandom), 1);
    end
    run(30000, 1);
    check_eq("a_leftover", ea_q.size(), 0);
    check_eq("d_leftover", ed_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tl_width_widget_narrow
`default_nettype wire
